// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: converts a Q3.29 Cartesian vector (x, y) into its
// magnitude and atan2(y, x) angle, one micro-rotation per clock.
module cordic_vectoring #(
  parameter int unsigned ITER      = 30,
  parameter int unsigned COMP_GAIN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [31:0] magnitude,
  output logic signed [31:0] angle,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned W  = 32;
  localparam int unsigned IW = 5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PREROT = 3'd1;
  localparam logic [2:0] S_ITER   = 3'd2;
  localparam logic [2:0] S_GAIN   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic signed [W-1:0]   POS_HALF_PI = 32'sh3243F6A8;
  localparam logic signed [W-1:0]   NEG_HALF_PI = 32'shCDBC0958;
  localparam logic signed [2*W-1:0] INV_K       = 64'sd326016437;
  localparam logic signed [2*W-1:0] GAIN_RND    = 64'sd268435456;
  localparam logic [IW-1:0]         LAST_ITER   = IW'(ITER - 1);

  // atan(2^-i) * 2^29, same contents as the shared arctan table
  function automatic logic signed [W-1:0] atan_lut(input logic [IW-1:0] idx);
    logic signed [W-1:0] v;
    case (idx)
      5'd0:  v = 32'sd421657428;
      5'd1:  v = 32'sd248918915;
      5'd2:  v = 32'sd131521918;
      5'd3:  v = 32'sd66762579;
      5'd4:  v = 32'sd33510843;
      5'd5:  v = 32'sd16771758;
      5'd6:  v = 32'sd8387925;
      5'd7:  v = 32'sd4194219;
      5'd8:  v = 32'sd2097141;
      5'd9:  v = 32'sd1048575;
      5'd10: v = 32'sd524288;
      5'd11: v = 32'sd262144;
      5'd12: v = 32'sd131072;
      5'd13: v = 32'sd65536;
      5'd14: v = 32'sd32768;
      5'd15: v = 32'sd16384;
      5'd16: v = 32'sd8192;
      5'd17: v = 32'sd4096;
      5'd18: v = 32'sd2048;
      5'd19: v = 32'sd1024;
      5'd20: v = 32'sd512;
      5'd21: v = 32'sd256;
      5'd22: v = 32'sd128;
      5'd23: v = 32'sd64;
      5'd24: v = 32'sd32;
      5'd25: v = 32'sd16;
      5'd26: v = 32'sd8;
      5'd27: v = 32'sd4;
      5'd28: v = 32'sd2;
      5'd29: v = 32'sd1;
      default: v = 32'sd0;
    endcase
    return v;
  endfunction

  logic [2:0]          state_q, state_d;
  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [W-1:0] z_q, z_d;
  logic [IW-1:0]       iter_q, iter_d;
  logic                zero_q, zero_d;
  logic signed [W-1:0] mag_q, mag_d;
  logic signed [W-1:0] ang_q, ang_d;
  logic                out_valid_q, out_valid_d;

  logic signed [W-1:0]   x_sh_c, y_sh_c, atan_c;
  logic signed [W-1:0]   x_rot_c, y_rot_c, z_rot_c;
  logic signed [2*W-1:0] prod_c;
  logic signed [W-1:0]   gain_c;

  // One micro-rotation driving y toward zero
  always_comb begin
    x_sh_c = x_q >>> iter_q;
    y_sh_c = y_q >>> iter_q;
    atan_c = atan_lut(iter_q);
    if (!y_q[W-1]) begin
      x_rot_c = x_q + y_sh_c;
      y_rot_c = y_q - x_sh_c;
      z_rot_c = z_q + atan_c;
    end else begin
      x_rot_c = x_q - y_sh_c;
      y_rot_c = y_q + x_sh_c;
      z_rot_c = z_q - atan_c;
    end
  end

  // Rounded 1/K gain compensation
  always_comb begin
    prod_c = 64'(x_q) * INV_K;
    gain_c = 32'((prod_c + GAIN_RND) >>> 29);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      iter_q      <= '0;
      zero_q      <= 1'b0;
      mag_q       <= '0;
      ang_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      iter_q      <= iter_d;
      zero_q      <= zero_d;
      mag_q       <= mag_d;
      ang_q       <= ang_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    iter_d      = iter_q;
    zero_d      = zero_q;
    mag_d       = mag_q;
    ang_d       = ang_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = S_PREROT;
        end
      end
      S_PREROT: begin
        // Fold left half-plane into right half; y == 0 takes +pi/2 so -x axis gives +pi
        iter_d  = '0;
        state_d = S_ITER;
        if (x_q[W-1]) begin
          if (!y_q[W-1]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = POS_HALF_PI;
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = NEG_HALF_PI;
          end
        end
      end
      S_ITER: begin
        x_d    = x_rot_c;
        y_d    = y_rot_c;
        z_d    = z_rot_c;
        iter_d = IW'(iter_q + 1'b1);
        if (iter_q == LAST_ITER) begin
          if (COMP_GAIN != 0) begin
            state_d = S_GAIN;
          end else begin
            state_d     = S_DONE;
            mag_d       = zero_q ? '0 : x_rot_c;
            ang_d       = zero_q ? '0 : z_rot_c;
            out_valid_d = 1'b1;
          end
        end
      end
      S_GAIN: begin
        state_d     = S_DONE;
        mag_d       = zero_q ? '0 : gain_c;
        ang_d       = zero_q ? '0 : z_q;
        out_valid_d = 1'b1;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = rst && (state_q == S_IDLE);
  assign magnitude = mag_q;
  assign angle     = ang_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: reference angles/magnitudes, latency,
// output hold under backpressure, and reset abort.
module tb_cordic_vectoring;

  localparam int unsigned ITER = 30;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] x_in, y_in;
  logic               in_valid, out_ready;
  logic               in_ready, out_valid;
  logic signed [31:0] magnitude, angle;

  logic               r_in_valid, r_out_ready;
  logic               r_in_ready, r_out_valid;
  logic signed [31:0] r_magnitude, r_angle;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m, a;
  int          lat;
  logic        seen;

  always #5 clk = ~clk;

  cordic_vectoring #(.ITER(ITER), .COMP_GAIN(1)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .magnitude(magnitude), .angle(angle),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  cordic_vectoring #(.ITER(ITER), .COMP_GAIN(0)) dut_raw (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in),
    .in_valid(r_in_valid), .in_ready(r_in_ready),
    .magnitude(r_magnitude), .angle(r_angle),
    .out_valid(r_out_valid), .out_ready(r_out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] got, input logic [31:0] exp,
                            input longint tol);
    longint d;
    logic   ok;
    d  = longint'($signed(got)) - longint'($signed(exp));
    ok = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1)
    else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d tol=%0d", tag, $signed(got), $signed(exp), tol);
    end
  endtask

  // Accept one vector, scramble the inputs, wait (bounded) for the result, then consume it
  task automatic run(input logic [31:0] xv, input logic [31:0] yv,
                     output logic [31:0] mo, output logic [31:0] ao, output int lo);
    x_in     = xv;
    y_in     = yv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x_in     = 32'h7FFF_FFFF;
    y_in     = 32'h8000_0000;
    lo       = 0;
    while (!out_valid && lo < 200) begin
      tick();
      lo++;
    end
    mo        = magnitude;
    ao        = angle;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    x_in        = '0;
    y_in        = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    r_in_valid  = 1'b0;
    r_out_ready = 1'b0;
    tick();
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_magnitude", magnitude, 32'd0);
    check("rst_angle", angle, 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // +x axis, also the latency reference
    run(32'h2000_0000, 32'h0, m, a, lat);
    check("posx_latency", 32'(lat), 32'(ITER + 2));
    check_near("posx_angle", a, 32'h0, 16);
    check_near("posx_mag", m, 32'h2000_0000, 48);
    check("posx_out_valid_drop", 32'(out_valid), 32'd0);
    check("posx_in_ready_back", 32'(in_ready), 32'd1);

    run(32'h0, 32'h2000_0000, m, a, lat);
    check_near("posy_angle", a, 32'h3243_F6A8, 16);
    check_near("posy_mag", m, 32'h2000_0000, 48);

    run(32'h0, 32'hE000_0000, m, a, lat);
    check_near("negy_angle", a, 32'hCDBC_0958, 16);
    check_near("negy_mag", m, 32'h2000_0000, 48);

    run(32'hE000_0000, 32'h0, m, a, lat);
    check_near("negx_angle", a, 32'h6487_ED51, 16);
    check("negx_angle_positive", 32'(a[31]), 32'd0);
    check_near("negx_mag", m, 32'h2000_0000, 48);

    run(32'h1000_0000, 32'h1000_0000, m, a, lat);
    check_near("q1_angle", a, 32'h1921_FB54, 16);
    check_near("q1_mag", m, 32'd379625062, 48);

    run(32'hF000_0000, 32'hF000_0000, m, a, lat);
    check_near("q3_angle", a, -32'sd1264972284, 16);
    check_near("q3_mag", m, 32'd379625062, 48);

    run(32'h0, 32'h0, m, a, lat);
    check("zero_latency", 32'(lat), 32'(ITER + 2));
    check("zero_mag", m, 32'h0);
    check("zero_angle", a, 32'h0);

    // Backpressure: hold out_ready low with a competing in_valid
    x_in     = 32'h1000_0000;
    y_in     = 32'h0;
    in_valid = 1'b1;
    tick();
    x_in = 32'h0;
    y_in = 32'h1000_0000;
    lat  = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("hold_latency", 32'(lat), 32'(ITER + 2));
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check_near("hold_mag", magnitude, 32'h1000_0000, 48);
      check_near("hold_angle", angle, 32'h0, 16);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("hold_release_out_valid", 32'(out_valid), 32'd0);
    check("hold_release_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-iteration aborts and clears outputs
    x_in     = 32'h2000_0000;
    y_in     = 32'h2000_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    rst = 1'b0;
    tick();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_magnitude", magnitude, 32'h0);
    check("abort_angle", angle, 32'h0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_idle", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    run(32'h0, 32'h1000_0000, m, a, lat);
    check("post_abort_latency", 32'(lat), 32'(ITER + 2));
    check_near("post_abort_angle", a, 32'h3243_F6A8, 16);
    check_near("post_abort_mag", m, 32'h1000_0000, 48);

    // Uncompensated instance: K-scaled magnitude, one cycle shorter
    x_in       = 32'h1000_0000;
    y_in       = 32'h1000_0000;
    r_in_valid = 1'b1;
    tick();
    r_in_valid = 1'b0;
    lat        = 0;
    while (!r_out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("raw_latency", 32'(lat), 32'(ITER + 1));
    check_near("raw_mag", r_magnitude, 32'd625151465, 256);
    check_near("raw_angle", r_angle, 32'h1921_FB54, 16);
    r_out_ready = 1'b1;
    tick();
    r_out_ready = 1'b0;
    check("raw_release", 32'(r_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
